// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with late-result hazard detection, bubble insertion,
// branch-flush handling, EX operand forwarding selects and a saturating stall counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_asel,
  input  logic              id_bsel,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_wbsel,
  input  logic              id_regwen,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              mem_valid,
  input  logic              mem_regwen,
  input  logic [4:0]        mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwen,
  input  logic [4:0]        wb_rd,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_asel,
  output logic              ex_bsel,
  output logic              ex_regwen,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_wbsel,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  logic ex_late;
  logic rs1_hit;
  logic rs2_hit;
  logic haz;
  logic bubble;
  logic mem_wr_ok;
  logic wb_wr_ok;

  // Result of the EX instruction is not available from the ALU (load or link).
  assign ex_late  = ex_valid & ex_regwen & (ex_wbsel != WB_ALU) & (ex_rd != 5'd0);
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign haz      = ex_late & id_valid & (rs1_hit | rs2_hit);
  assign stall_id = haz & ~flush;
  assign bubble   = flush | haz;

  assign mem_wr_ok = mem_valid & mem_regwen & (mem_rd != 5'd0);
  assign wb_wr_ok  = wb_valid & wb_regwen & (wb_rd != 5'd0);

  always_comb begin
    forward_a = FWD_NONE;
    if (!ex_asel) begin
      if (mem_wr_ok && (mem_rd == ex_rs1))
        forward_a = FWD_MEM;
      else if (wb_wr_ok && (wb_rd == ex_rs1))
        forward_a = FWD_WB;
    end
  end

  always_comb begin
    forward_b = FWD_NONE;
    if (!ex_bsel) begin
      if (mem_wr_ok && (mem_rd == ex_rs2))
        forward_b = FWD_MEM;
      else if (wb_wr_ok && (wb_rd == ex_rs2))
        forward_b = FWD_WB;
    end
  end

  // Control fields: a bubble only kills the side-effecting bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_regwen   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_regwen   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_regwen   <= id_valid & id_regwen;
      ex_memread  <= id_valid & id_memread;
      ex_memwrite <= id_valid & id_memwrite;
    end
  end

  // Operand and select fields are held across a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_asel   <= 1'b0;
      ex_bsel   <= 1'b0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      ex_rd     <= 5'd0;
      ex_alu_op <= 4'd0;
      ex_wbsel  <= WB_ALU;
    end else if (!bubble) begin
      ex_asel   <= id_asel;
      ex_bsel   <= id_bsel;
      ex_pc     <= id_pc;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_alu_op <= id_alu_op;
      ex_wbsel  <= id_wbsel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall_id && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of the
// ID/EX register, hazard stall, forwarding selects and saturating stall counter.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush, id_valid;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_uses_rs1, id_uses_rs2, id_asel, id_bsel;
  logic [3:0] id_alu_op;
  logic [1:0] id_wbsel;
  logic id_regwen, id_memread, id_memwrite;
  logic mem_valid, mem_regwen, wb_valid, wb_regwen;
  logic [4:0] mem_rd, wb_rd;

  logic stall_id, ex_valid, ex_asel, ex_bsel, ex_regwen, ex_memread, ex_memwrite;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm, stall_count;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_wbsel, forward_a, forward_b;

  logic s_stall_id, s_ex_valid, s_ex_asel, s_ex_bsel, s_ex_regwen, s_ex_memread, s_ex_memwrite;
  logic [31:0] s_ex_pc, s_ex_rdata1, s_ex_rdata2, s_ex_imm;
  logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [3:0] s_ex_alu_op, s_stall_count;
  logic [1:0] s_ex_wbsel, s_forward_a, s_forward_b;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_alu_op(id_alu_op), .id_wbsel(id_wbsel),
    .id_regwen(id_regwen), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_valid(mem_valid), .mem_regwen(mem_regwen), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwen(wb_regwen), .wb_rd(wb_rd),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_asel(ex_asel), .ex_bsel(ex_bsel),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_wbsel(ex_wbsel), .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count)
  );

  // Narrow-counter instance sharing all inputs, used for saturation.
  id_ex_stage #(.XLEN(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_alu_op(id_alu_op), .id_wbsel(id_wbsel),
    .id_regwen(id_regwen), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_valid(mem_valid), .mem_regwen(mem_regwen), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwen(wb_regwen), .wb_rd(wb_rd),
    .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_asel(s_ex_asel), .ex_bsel(s_ex_bsel),
    .ex_regwen(s_ex_regwen), .ex_memread(s_ex_memread), .ex_memwrite(s_ex_memwrite),
    .ex_pc(s_ex_pc), .ex_rdata1(s_ex_rdata1), .ex_rdata2(s_ex_rdata2), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_alu_op(s_ex_alu_op),
    .ex_wbsel(s_ex_wbsel), .forward_a(s_forward_a), .forward_b(s_forward_b),
    .stall_count(s_stall_count)
  );

  // Model of the instruction sitting in EX.
  bit m_valid, m_asel, m_bsel, m_regwen, m_memread, m_memwrite;
  bit [31:0] m_pc, m_rd1, m_rd2, m_imm;
  bit [4:0] m_rs1, m_rs2, m_rd;
  bit [3:0] m_alu_op;
  bit [1:0] m_wbsel;
  longint m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_valid = 0; m_asel = 0; m_bsel = 0; m_regwen = 0; m_memread = 0; m_memwrite = 0;
    m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_alu_op = 0; m_wbsel = 2'b01; m_cnt = 0;
  endfunction

  // A consumer in ID must wait when the EX producer's value comes from memory or PC+4.
  function automatic bit m_stall();
    bit late, reads;
    late  = m_valid && m_regwen && m_wbsel != 2'b01 && m_rd != 0;
    reads = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
    return late && id_valid && reads && !flush;
  endfunction

  function automatic bit [1:0] m_fwd(input bit alt, input bit [4:0] rs);
    if (alt) return 2'b00;
    if (mem_valid && mem_regwen && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_valid && wb_regwen && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void m_clock();
    bit st, haz;
    if (rst) begin
      m_reset();
      return;
    end
    st  = m_stall();
    haz = st || (flush && m_valid && m_regwen && m_wbsel != 2'b01 && m_rd != 0 && id_valid &&
                 ((id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd)));
    if (flush || haz) begin
      m_valid = 0; m_regwen = 0; m_memread = 0; m_memwrite = 0;
    end else begin
      m_valid = id_valid; m_asel = id_asel; m_bsel = id_bsel;
      m_regwen = id_valid && id_regwen; m_memread = id_valid && id_memread;
      m_memwrite = id_valid && id_memwrite;
      m_pc = id_pc; m_rd1 = id_rdata1; m_rd2 = id_rdata2; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_alu_op = id_alu_op; m_wbsel = id_wbsel;
    end
    if (st) m_cnt++;
  endfunction

  function automatic logic [63:0] sat4();
    return (m_cnt > 15) ? 64'd15 : 64'(m_cnt);
  endfunction

  task automatic compare_all();
    check("stall_id", stall_id, m_stall());
    check("ex_valid", ex_valid, m_valid);
    check("ex_regwen", ex_regwen, m_regwen);
    check("ex_memread", ex_memread, m_memread);
    check("ex_memwrite", ex_memwrite, m_memwrite);
    check("ex_asel", ex_asel, m_asel);
    check("ex_bsel", ex_bsel, m_bsel);
    check("ex_pc", ex_pc, m_pc);
    check("ex_rdata1", ex_rdata1, m_rd1);
    check("ex_rdata2", ex_rdata2, m_rd2);
    check("ex_imm", ex_imm, m_imm);
    check("ex_rs1", ex_rs1, m_rs1);
    check("ex_rs2", ex_rs2, m_rs2);
    check("ex_rd", ex_rd, m_rd);
    check("ex_alu_op", ex_alu_op, m_alu_op);
    check("ex_wbsel", ex_wbsel, m_wbsel);
    check("forward_a", forward_a, m_fwd(m_asel, m_rs1));
    check("forward_b", forward_b, m_fwd(m_bsel, m_rs2));
    check("stall_count", stall_count, (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_cnt));
    check("sat_stall_count", s_stall_count, sat4());
    check("sat_stall_id", s_stall_id, m_stall());
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_pc = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_asel = 0; id_bsel = 0; id_alu_op = 0; id_wbsel = 2'b01;
    id_regwen = 0; id_memread = 0; id_memwrite = 0;
  endtask

  task automatic id_instr(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                          input bit u1, input bit u2, input bit [1:0] wbsel, input bit asel);
    id_clear();
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_wbsel = wbsel; id_regwen = (rd != 0) || wbsel == 2'b00;
    id_memread = (wbsel == 2'b00); id_asel = asel;
    id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom_range(0, 15));
  endtask

  task automatic mem_wb(input bit mv, input bit [4:0] mr, input bit wv, input bit [4:0] wr);
    mem_valid = mv; mem_regwen = mv; mem_rd = mr;
    wb_valid = wv; wb_regwen = wv; wb_rd = wr;
  endtask

  initial begin
    rst = 1; flush = 0;
    id_clear();
    mem_wb(0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    at_neg();
    check("reset_wbsel", ex_wbsel, 2'b01);
    check("reset_count", stall_count, 0);

    // ALU -> ALU: add x5 then sub x6, x5, x1
    id_instr(5'd1, 5'd2, 5'd5, 1, 1, 2'b01, 0);
    edge_step();
    id_instr(5'd5, 5'd1, 5'd6, 1, 1, 2'b01, 0);
    at_neg();
    check("alu_no_stall", stall_id, 0);
    edge_step();
    id_clear();
    mem_wb(1, 5'd5, 0, 0);
    at_neg();
    check("alu_fwd_a", forward_a, 2'b10);
    check("alu_fwd_b", forward_b, 2'b00);

    // Load-use: lw x7 then consumer reading x7 via rs2
    edge_step();
    mem_wb(0, 0, 0, 0);
    id_instr(5'd2, 5'd0, 5'd7, 1, 0, 2'b00, 0);
    edge_step();
    id_instr(5'd1, 5'd7, 5'd8, 1, 1, 2'b01, 0);
    at_neg();
    check("lu_stall", stall_id, 1);
    edge_step();
    mem_wb(1, 5'd7, 0, 0);
    at_neg();
    check("lu_bubble", ex_valid, 0);
    check("lu_stall_once", stall_id, 0);
    check("lu_count", stall_count, 1);
    edge_step();
    id_clear();
    mem_wb(0, 0, 1, 5'd7);
    at_neg();
    check("lu_enter", ex_valid, 1);
    check("lu_fwd_b", forward_b, 2'b01);

    // Dual match: MEM wins; PC operand never forwarded
    edge_step();
    id_instr(5'd3, 5'd0, 5'd4, 1, 0, 2'b01, 0);
    edge_step();
    id_instr(5'd3, 5'd0, 5'd4, 1, 0, 2'b01, 1);
    mem_wb(1, 5'd3, 1, 5'd3);
    at_neg();
    check("dual_mem_wins", forward_a, 2'b10);
    edge_step();
    id_clear();
    at_neg();
    check("dual_asel", forward_a, 2'b00);

    // Flush during a hazard
    edge_step();
    mem_wb(0, 0, 0, 0);
    id_instr(5'd1, 5'd0, 5'd9, 1, 0, 2'b00, 0);
    edge_step();
    id_instr(5'd9, 5'd0, 5'd10, 1, 0, 2'b01, 0);
    flush = 1;
    at_neg();
    check("flush_no_stall", stall_id, 0);
    edge_step();
    flush = 0;
    id_clear();
    at_neg();
    check("flush_bubble", ex_valid, 0);
    check("flush_count", stall_count, 1);

    // x0 producer never stalls or forwards
    edge_step();
    id_instr(5'd1, 5'd0, 5'd0, 1, 0, 2'b00, 0);
    edge_step();
    id_instr(5'd0, 5'd0, 5'd11, 1, 0, 2'b01, 0);
    mem_wb(1, 5'd0, 1, 5'd0);
    at_neg();
    check("x0_no_stall", stall_id, 0);
    edge_step();
    id_clear();
    at_neg();
    check("x0_no_fwd", forward_a, 2'b00);
    edge_step();
    mem_wb(0, 0, 0, 0);

    // Saturation of the 4-bit counter: 17 more load-use stalls
    for (int i = 0; i < 17; i++) begin
      id_instr(5'd1, 5'd0, 5'd7, 1, 0, 2'b00, 0);
      at_neg();
      edge_step();
      id_instr(5'd7, 5'd0, 5'd8, 1, 0, 2'b01, 0);
      at_neg();
      edge_step();
      at_neg();
      edge_step();
    end
    id_clear();
    at_neg();
    check("sat_hold_F", s_stall_count, 4'hF);
    check("wide_count_18", stall_count, 18);
    edge_step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_asel = ($urandom_range(0, 3) == 0); id_bsel = ($urandom_range(0, 2) == 0);
      id_alu_op = 4'($urandom); id_wbsel = 2'($urandom);
      id_regwen = ($urandom_range(0, 4) != 0); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
      mem_valid = 1'($urandom); mem_regwen = 1'($urandom); mem_rd = 5'($urandom_range(0, 7));
      wb_valid = 1'($urandom); wb_regwen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
      at_neg();
      edge_step();
    end

    // Asynchronous reset mid-cycle with a valid instruction in EX
    flush = 0;
    id_instr(5'd3, 5'd4, 5'd5, 1, 1, 2'b01, 0);
    mem_wb(1, 5'd3, 0, 0);
    edge_step();
    at_neg();
    check("pre_reset_valid", ex_valid, 1);
    rst = 1;
    #1;
    check("async_rst_valid", ex_valid, 0);
    check("async_rst_fwd_a", forward_a, 2'b00);
    check("async_rst_count", stall_count, 0);
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    id_clear();
    at_neg();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
